// File: rtl/gate_sweep_pkg.sv
// Shared types, gate index constants and the reduction-based expected-value
// function for the gate sweep checker.
package gate_sweep_pkg;

  localparam int unsigned NUM_GATES = 6;
  localparam int unsigned MAX_WIDTH = 16;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_OR   = 1;
  localparam int unsigned GATE_XOR  = 2;
  localparam int unsigned GATE_XNOR = 3;
  localparam int unsigned GATE_NAND = 4;
  localparam int unsigned GATE_NOR  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Expected outputs of the six gates for the low 'width' bits of vec.
  // Bits above 'width' are treated as absent: they are forced to the
  // identity element of each reduction so they never influence the result.
  function automatic logic [NUM_GATES-1:0] gate_expect(
    input logic [MAX_WIDTH-1:0] vec,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] live;
    logic [MAX_WIDTH-1:0] v;
    logic [NUM_GATES-1:0] y;
    live = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) live[i] = 1'b1;
    end
    v = vec & live;
    y[GATE_AND]  = &(v | ~live);
    y[GATE_OR]   = |v;
    y[GATE_XOR]  = ^v;
    y[GATE_XNOR] = ~^v;
    y[GATE_NAND] = ~&(v | ~live);
    y[GATE_NOR]  = ~|v;
    return y;
  endfunction

endpackage

// File: rtl/gate_sweep_model.sv
// Combinational expected-value generator: the six reference gate outputs for
// a WIDTH-bit input vector. Also usable as a golden gate block.
module gate_sweep_model
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]     vec_i,
  output logic [NUM_GATES-1:0] y_o
);

  logic [MAX_WIDTH-1:0] vec_ext;

  // Zero-extend to the package width and evaluate the reductions.
  always_comb begin
    vec_ext              = '0;
    vec_ext[WIDTH-1:0]   = vec_i;
    y_o                  = gate_expect(vec_ext, $unsigned(WIDTH));
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus-and-check stage for a six-gate primitive block.
// Sweeps every WIDTH-bit vector, registers the per-gate compare one cycle
// later and folds it into a saturating mismatch count, a sticky gate mask
// and the first failing vector.
// Optional build macro: GATE_SWEEP_ASSERT_EN adds an immediate assertion
// that fires on every captured mismatch.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for start_i, results hold reset values
//   ST_RUN   | presenting vectors, one per unpaused cycle
//   ST_DRAIN | sweep presented, folding the final capture
//   ST_DONE  | results stable, start_i launches a fresh sweep
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 pause_i,
  input  logic [NUM_GATES-1:0] dut_y_i,
  output logic [WIDTH-1:0]     vec_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [NUM_GATES-1:0] err_mask_o,
  output logic [WIDTH-1:0]     first_fail_vec_o,
  output logic                 first_fail_vld_o
);

  localparam logic [WIDTH-1:0] VEC_ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_e state_q, state_d;

  logic [WIDTH-1:0]     vec_q, vec_d;
  logic [NUM_GATES-1:0] mm_q, mm_d;
  logic [WIDTH-1:0]     vv_q, vv_d;
  logic                 cap_q, cap_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [NUM_GATES-1:0] err_mask_q, err_mask_d;
  logic [WIDTH-1:0]     ff_vec_q, ff_vec_d;
  logic                 ff_vld_q, ff_vld_d;

  logic [NUM_GATES-1:0] exp_y;
  logic                 start_go;
  logic                 advance;
  logic                 last_vec;

  gate_sweep_model #(
    .WIDTH (WIDTH)
  ) u_model (
    .vec_i (vec_q),
    .y_o   (exp_y)
  );

  // start_i only matters when no sweep is in flight.
  assign start_go = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign advance  = (state_q == ST_RUN) && !pause_i;
  assign last_vec = (vec_q == VEC_ALL_ONES);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_go) state_d = ST_RUN;
      ST_RUN:   if (advance && last_vec) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (start_go) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM status outputs.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_RUN, ST_DRAIN: busy_o = 1'b1;
      ST_DONE:          done_o = 1'b1;
      default:          ;
    endcase
  end

  // Vector counter and capture stage; a paused cycle leaves everything but
  // cap_q untouched so the fold never sees the same capture twice.
  always_comb begin
    vec_d = vec_q;
    mm_d  = mm_q;
    vv_d  = vv_q;
    cap_d = advance;
    if (start_go) begin
      vec_d = '0;
    end else if (advance) begin
      vec_d = vec_q + WIDTH'(1);
      mm_d  = dut_y_i ^ exp_y;
      vv_d  = vec_q;
    end
  end

  // Fold stage: accumulate the previous cycle's capture into the results.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
    ff_vec_d   = ff_vec_q;
    ff_vld_d   = ff_vld_q;
    if (start_go) begin
      err_cnt_d  = '0;
      err_mask_d = '0;
      ff_vec_d   = '0;
      ff_vld_d   = 1'b0;
    end else if (cap_q) begin
      err_mask_d = err_mask_q | mm_q;
      if (mm_q != '0) begin
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!ff_vld_q) begin
          ff_vec_d = vv_q;
          ff_vld_d = 1'b1;
        end
      end
    end
  end

  // Datapath registers; reset discards any partial sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q      <= '0;
      mm_q       <= '0;
      vv_q       <= '0;
      cap_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
      ff_vec_q   <= '0;
      ff_vld_q   <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      mm_q       <= mm_d;
      vv_q       <= vv_d;
      cap_q      <= cap_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
      ff_vec_q   <= ff_vec_d;
      ff_vld_q   <= ff_vld_d;
    end
  end

  assign vec_o            = vec_q;
  assign err_cnt_o        = err_cnt_q;
  assign err_mask_o       = err_mask_q;
  assign first_fail_vec_o = ff_vec_q;
  assign first_fail_vld_o = ff_vld_q;

`ifdef GATE_SWEEP_ASSERT_EN
  // Flag each captured vector whose gate outputs disagree with expectation.
  always_comb begin
    if (cap_q) begin
      assert (mm_q == '0)
        else $error("gate_sweep_checker: vector %0h mismatch mask %b", vv_q, mm_q);
    end
  end
`else
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: golden model table, directed corner-case
// sweeps and randomized fault/pause sweeps against a reference model.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  logic [5:0] dut_y_a, dut_y_b;
  logic [2:0] vec_a, vec_b, ffv_a, ffv_b;
  logic       busy_a, busy_b, done_a, done_b, ffvld_a, ffvld_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [5:0] mask_a, mask_b;

  logic [2:0] tvec;
  logic [5:0] gold_y;
  logic       tvec1;
  logic [5:0] gold1_y;

  logic [5:0] err_tab [8];
  bit         pz [64];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference gate outputs from a population count, independent of reductions.
  function automatic logic [5:0] bexp(input int v);
    int pc;
    logic [5:0] y;
    pc = 0;
    for (int i = 0; i < 3; i++) pc += (v >> i) & 1;
    y[0] = (pc == 3);
    y[1] = (pc != 0);
    y[2] = (pc % 2 == 1);
    y[3] = (pc % 2 == 0);
    y[4] = (pc != 3);
    y[5] = (pc == 0);
    return y;
  endfunction

  always_comb dut_y_a = bexp(int'(vec_a)) ^ err_tab[vec_a];
  always_comb dut_y_b = bexp(int'(vec_b)) ^ err_tab[vec_b];

  gate_sweep_checker #(.WIDTH(3), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .dut_y_i(dut_y_a),
    .vec_o(vec_a), .busy_o(busy_a), .done_o(done_a), .err_cnt_o(cnt_a),
    .err_mask_o(mask_a), .first_fail_vec_o(ffv_a), .first_fail_vld_o(ffvld_a));

  gate_sweep_checker #(.WIDTH(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .dut_y_i(dut_y_b),
    .vec_o(vec_b), .busy_o(busy_b), .done_o(done_b), .err_cnt_o(cnt_b),
    .err_mask_o(mask_b), .first_fail_vec_o(ffv_b), .first_fail_vld_o(ffvld_b));

  gate_sweep_model #(.WIDTH(3)) u_gold  (.vec_i(tvec),  .y_o(gold_y));
  gate_sweep_model #(.WIDTH(1)) u_gold1 (.vec_i(tvec1), .y_o(gold1_y));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int v = 0; v < 8; v++) err_tab[v] = 6'd0;
    for (int c = 0; c < 64; c++) pz[c] = 1'b0;
  endtask

  // One full sweep: start pulse, per-cycle timing checks, final results.
  task automatic sweep(input bit poke_start, input string tag);
    int total, adv, cnt_ref, first_ref, cnt_m, pend;
    logic [5:0] mask_ref;
    bit pend_vld;
    total = 0; adv = 0;
    while (adv < 8) begin
      if (!pz[total]) adv++;
      total++;
    end
    total++;
    cnt_ref = 0; mask_ref = 6'd0; first_ref = -1;
    for (int v = 0; v < 8; v++) begin
      mask_ref |= err_tab[v];
      if (err_tab[v] != 6'd0) begin
        cnt_ref++;
        if (first_ref < 0) first_ref = v;
      end
    end

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, " clr_cnt"},  int'(cnt_a),   0);
    chk({tag, " clr_mask"}, int'(mask_a),  0);
    chk({tag, " clr_vld"},  int'(ffvld_a), 0);

    adv = 0; cnt_m = 0; pend = 0; pend_vld = 1'b0;
    for (int c = 0; c < total; c++) begin
      pause = pz[c];
      start = poke_start && (c == 2);
      @(negedge clk);
      chk({tag, " busy"}, int'(busy_a), 1);
      chk({tag, " done_early"}, int'(done_a), 0);
      chk({tag, " vec_a"}, int'(vec_a), (adv < 8) ? adv : 0);
      chk({tag, " vec_b"}, int'(vec_b), (adv < 8) ? adv : 0);
      chk({tag, " run_cnt"}, int'(cnt_a), cnt_m);
      @(posedge clk);
      if (pend_vld && err_tab[pend] != 6'd0) cnt_m++;
      pend_vld = (adv < 8) && !pz[c];
      pend = adv;
      if (pend_vld) adv++;
      #1;
    end
    pause = 1'b0; start = 1'b0;
    @(negedge clk);
    chk({tag, " done_a"}, int'(done_a), 1);
    chk({tag, " done_b"}, int'(done_b), 1);
    chk({tag, " busy_end"}, int'(busy_a), 0);
    chk({tag, " cnt_a"}, int'(cnt_a), cnt_ref);
    chk({tag, " cnt_b"}, int'(cnt_b), (cnt_ref > 3) ? 3 : cnt_ref);
    chk({tag, " mask_a"}, int'(mask_a), int'(mask_ref));
    chk({tag, " mask_b"}, int'(mask_b), int'(mask_ref));
    chk({tag, " ffvld_a"}, int'(ffvld_a), (first_ref >= 0) ? 1 : 0);
    chk({tag, " ffvld_b"}, int'(ffvld_b), (first_ref >= 0) ? 1 : 0);
    if (first_ref >= 0) begin
      chk({tag, " ffvec_a"}, int'(ffv_a), first_ref);
      chk({tag, " ffvec_b"}, int'(ffv_b), first_ref);
    end
  endtask

  typedef struct {
    logic [2:0] vec;
    logic [5:0] y;
  } model_rec_t;

  model_rec_t tbl [8];

  initial begin
    for (int v = 0; v < 8; v++) begin
      tbl[v].vec = 3'(v);
      tbl[v].y   = bexp(v);
    end
    clear_cfg();
    tvec = 3'd0; tvec1 = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst vec",   int'(vec_a),   0);
    chk("rst busy",  int'(busy_a),  0);
    chk("rst done",  int'(done_a),  0);
    chk("rst cnt",   int'(cnt_a),   0);
    chk("rst mask",  int'(mask_a),  0);
    chk("rst ffvec", int'(ffv_a),   0);
    chk("rst ffvld", int'(ffvld_a), 0);

    for (int i = 0; i < 8; i++) begin
      tvec = tbl[i].vec;
      #1;
      chk("model w3", int'(gold_y), int'(tbl[i].y));
    end
    tvec1 = 1'b0; #1;
    chk("model w1 v0", int'(gold1_y), 6'b111000);
    tvec1 = 1'b1; #1;
    chk("model w1 v1", int'(gold1_y), 6'b000111);

    clear_cfg();
    sweep(1'b0, "clean");

    clear_cfg();
    for (int v = 0; v < 8; v++) err_tab[v] = bexp(v) & 6'b000100;
    sweep(1'b0, "xor0");
    chk("xor0 cnt4", int'(cnt_a), 4);
    chk("xor0 first", int'(ffv_a), 1);

    clear_cfg();
    for (int c = 3; c < 8; c++) pz[c] = 1'b1;
    sweep(1'b0, "pause");

    clear_cfg();
    for (int v = 0; v < 8; v++) err_tab[v] = 6'b010000;
    sweep(1'b0, "nand_inv");
    chk("nand sat", int'(cnt_b), 3);

    clear_cfg();
    for (int v = 0; v < 8; v++) err_tab[v] = bexp(v) & 6'b000100;
    sweep(1'b1, "poke");

    clear_cfg();
    err_tab[0] = 6'b000001; err_tab[1] = 6'b100000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst vec", int'(vec_a), 4);
    chk("pre_rst cnt", int'(cnt_a), 2);
    rst = 1'b1;
    #1;
    chk("rst2 vec",   int'(vec_a),   0);
    chk("rst2 busy",  int'(busy_a),  0);
    chk("rst2 done",  int'(done_a),  0);
    chk("rst2 cnt",   int'(cnt_a),   0);
    chk("rst2 mask",  int'(mask_a),  0);
    chk("rst2 ffvec", int'(ffv_a),   0);
    chk("rst2 ffvld", int'(ffvld_a), 0);
    #1 rst = 1'b0;
    sweep(1'b0, "after_rst");

    for (int r = 0; r < 6; r++) begin
      clear_cfg();
      for (int v = 0; v < 8; v++)
        err_tab[v] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
      for (int c = 0; c < 40; c++) pz[c] = ($urandom_range(0, 3) == 0);
      sweep(1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
